// File: rtl/riscv_tag_check_unit.sv
// riscv_tag_check_unit
//
// EX-stage tag check. Compares the per-instruction check enables from the ID
// check decoder against the operand, result and PC tags. It kills the side
// effects of a violating instruction in the same cycle. It then raises an
// exception request and holds it, with the pipeline stalled, until the
// controller acknowledges it. A sticky cause/PC record and a saturating
// violation counter are kept for CSR readout.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   dift_en_i                global tag-check enable
//   ex_valid_i               valid instruction in EX
//   source_1_i .. execute_pc_i  check enables for rs1/rs2/rd/PC tags
//   rs1_tag_i .. pc_tag_i    tags (tainted when any bit is set)
//   pc_ex_i                  PC of the EX instruction
//   exc_ack_i                controller accepted the exception
//   cnt_clr_i                synchronous clear of the violation counter
//   kill_o                   combinational kill of RF write / LSU request
//   stall_o                  freeze IF/ID/EX while the request is pending
//   exc_req_o                tag-violation exception request
//   exc_cause_o              {pc,d,s2,s1} violation bits of the trapped instr
//   exc_addr_o               PC of the trapped instruction
//   viol_cnt_o               saturating violation count
module riscv_tag_check_unit #(
  parameter int TAG_WIDTH = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dift_en_i,
  input  logic                 ex_valid_i,
  input  logic                 source_1_i,
  input  logic                 source_2_i,
  input  logic                 dest_i,
  input  logic                 execute_pc_i,
  input  logic [TAG_WIDTH-1:0] rs1_tag_i,
  input  logic [TAG_WIDTH-1:0] rs2_tag_i,
  input  logic [TAG_WIDTH-1:0] rd_tag_i,
  input  logic [TAG_WIDTH-1:0] pc_tag_i,
  input  logic [31:0]          pc_ex_i,
  input  logic                 exc_ack_i,
  input  logic                 cnt_clr_i,
  output logic                 kill_o,
  output logic                 stall_o,
  output logic                 exc_req_o,
  output logic [3:0]           exc_cause_o,
  output logic [31:0]          exc_addr_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  logic                 exc_req_reg;
  logic                 stall_reg;
  logic [3:0]           cause_reg;
  logic [31:0]          addr_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;

  logic [3:0] viol;
  logic       hit;

  assign viol = {execute_pc_i & (|pc_tag_i),
                 dest_i       & (|rd_tag_i),
                 source_2_i   & (|rs2_tag_i),
                 source_1_i   & (|rs1_tag_i)};

  // Only checked in IDLE: while a request is pending the EX instruction is
  // stalled and will be re-presented after the ack. Reset also masks the
  // kill, so no kill can appear while rst is held.
  assign hit    = ~rst & dift_en_i & ex_valid_i & (state == IDLE) & (|viol);
  assign kill_o = hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      exc_req_reg <= 1'b0;
      stall_reg   <= 1'b0;
      cause_reg   <= 4'b0000;
      addr_reg    <= 32'h0000_0000;
      cnt_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state       <= REQ;
            exc_req_reg <= 1'b1;
            stall_reg   <= 1'b1;
            cause_reg   <= viol;
            addr_reg    <= pc_ex_i;
          end
        end
        REQ: begin
          if (exc_ack_i) begin
            state       <= IDLE;
            exc_req_reg <= 1'b0;
            stall_reg   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          exc_req_reg <= 1'b0;
          stall_reg   <= 1'b0;
        end
      endcase

      // Clear wins over a simultaneous increment.
      if (cnt_clr_i) begin
        cnt_reg <= '0;
      end else if (hit && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign exc_req_o   = exc_req_reg;
  assign stall_o     = stall_reg;
  assign exc_cause_o = cause_reg;
  assign exc_addr_o  = addr_reg;
  assign viol_cnt_o  = cnt_reg;

endmodule
